trb_mem_arbiter: RTL and testbench

- Owns the trace-buffer RAM and arbitrates all access to it.
- Sits directly downstream of the trace logger's memory port and consumes its WRITE/pointer/data outputs.
- Returns the turn strobe, the write/read permission flags, the read data and the fill level.
- Alternates write and read turns so a single-port-style RAM sees at most one access per cycle.

---
 rtl/trb_mem_arbiter.sv | 87 ++++++++
 tb/tb_trb_mem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/trb_mem_arbiter.sv
// Trace-buffer RAM owner: alternates write/read turns, commits logger writes,
// serves reads and derives full/empty/fill status from the two pointers.
package trb_pkg;
  localparam int TRB_ADDR_WIDTH = 4;
  localparam int TRB_WIDTH      = 8;
endpackage

module trb_mem_arbiter
  import trb_pkg::*;
#(
  parameter int ADDR_WIDTH = TRB_ADDR_WIDTH,
  parameter int WIDTH      = TRB_WIDTH
) (
  input  logic                  CLK_I,
  input  logic                  RST_I,
  output logic                  RW_TURN_O,
  input  logic                  WRITE_I,
  input  logic [ADDR_WIDTH-1:0] WRITE_PTR_I,
  input  logic [WIDTH-1:0]      DATA_I,
  input  logic [ADDR_WIDTH-1:0] READ_PTR_I,
  output logic [WIDTH-1:0]      DATA_O,
  output logic                  WRITE_ALLOW_O,
  output logic                  READ_ALLOW_O,
  output logic [ADDR_WIDTH:0]   FILL_O,
  output logic                  DROP_O
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [WIDTH-1:0]      mem [DEPTH];
  logic                  turn;
  logic                  last_wr;
  logic                  drop;
  logic [ADDR_WIDTH-1:0] rd_prev;
  logic [ADDR_WIDTH-1:0] ptr_diff;
  logic                  eq, full, empty, commit, drop_req;

  // Equal pointers are ambiguous; last_wr records whether the writer caught up.
  always_comb begin
    eq       = (WRITE_PTR_I == READ_PTR_I);
    full     = eq & last_wr;
    empty    = eq & ~last_wr;
    ptr_diff = WRITE_PTR_I - READ_PTR_I;
    commit   = WRITE_I & turn & ~full;
    drop_req = WRITE_I & turn & full;
  end

  assign RW_TURN_O     = turn;
  assign WRITE_ALLOW_O = ~full;
  assign READ_ALLOW_O  = ~empty;
  assign DROP_O        = drop;
  assign FILL_O        = full ? {1'b1, {ADDR_WIDTH{1'b0}}} : {1'b0, ptr_diff};

  // NOTE: the RAM array has no reset branch so it maps onto block RAM and keeps
  // its trace across a mid-operation reset; only the write enable sees RST_I.
  always_ff @(posedge CLK_I) begin
    if (commit && !RST_I) begin
      mem[WRITE_PTR_I] <= DATA_I;
    end
  end

  // NOTE: all state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      turn    <= 1'b0;
      DATA_O  <= '0;
      last_wr <= 1'b0;
      rd_prev <= '0;
      drop    <= 1'b0;
    end else begin
      turn    <= ~turn;
      drop    <= drop_req;
      rd_prev <= READ_PTR_I;
      if (!turn) begin
        DATA_O <= mem[READ_PTR_I];
      end
      // A commit outranks a read-pointer move seen in the same cycle.
      if (commit) begin
        last_wr <= 1'b1;
      end else if (READ_PTR_I != rd_prev) begin
        last_wr <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trb_mem_arbiter.sv
// Self-checking bench: behavioural buffer model checked every cycle, plus
// directed scenarios with hand-computed expectations.
module tb_trb_mem_arbiter;
  localparam int AW    = 4;
  localparam int W     = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          rw_turn;
  logic          we = 1'b0;
  logic [AW-1:0] wp = '0;
  logic [W-1:0]  din = '0;
  logic [AW-1:0] rp = '0;
  logic [W-1:0]  dout;
  logic          wr_allow, rd_allow, drop;
  logic [AW:0]   fill;

  int checks = 0;
  int errors = 0;

  trb_mem_arbiter #(.ADDR_WIDTH(AW), .WIDTH(W)) dut (
    .CLK_I(clk), .RST_I(rst), .RW_TURN_O(rw_turn), .WRITE_I(we),
    .WRITE_PTR_I(wp), .DATA_I(din), .READ_PTR_I(rp), .DATA_O(dout),
    .WRITE_ALLOW_O(wr_allow), .READ_ALLOW_O(rd_allow), .FILL_O(fill),
    .DROP_O(drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          m_valid = 0;
  bit          m_turn;            // 1 on odd cycles since reset
  bit [W-1:0]  m_mem [DEPTH];
  bit          m_writer_caught_up; // last pointer event was a write
  int          m_prev_rp;
  bit [W-1:0]  m_data;
  bit          m_drop;

  function automatic bit m_full();
    return (wp == rp) && m_writer_caught_up;
  endfunction

  function automatic int m_fill();
    if (wp == rp) return m_writer_caught_up ? DEPTH : 0;
    return (int'(wp) - int'(rp) + DEPTH) % DEPTH;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_valid = 1;
      m_turn = 0; m_data = '0; m_writer_caught_up = 0; m_prev_rp = 0; m_drop = 0;
    end else if (m_valid) begin
      bit accepted;
      accepted = we && m_turn && !m_full();
      m_drop   = we && m_turn && m_full();
      if (!m_turn) m_data = m_mem[rp];
      if (accepted) m_mem[wp] = din;
      if (accepted) m_writer_caught_up = 1;
      else if (int'(rp) != m_prev_rp) m_writer_caught_up = 0;
      m_prev_rp = int'(rp);
      m_turn = !m_turn;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("turn",        32'(rw_turn),  32'(m_turn));
      check("data",        32'(dout),     32'(m_data));
      check("drop",        32'(drop),     32'(m_drop));
      check("write_allow", 32'(wr_allow), 32'(!m_full()));
      check("read_allow",  32'(rd_allow), 32'(m_fill() != 0));
      check("fill",        32'(fill),     32'(m_fill()));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic to_turn(input bit t);
    if (m_turn != t) tick();
  endtask

  task automatic do_reset();
    rst = 1'b1; tick(); rst = 1'b0;
  endtask

  bit [W-1:0] saved [DEPTH];

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and idle turn pattern
    tick();
    do_reset();
    settle();
    check("rst_turn0", 32'(rw_turn), 0);
    check("rst_fill", 32'(fill), 0);
    check("rst_rd_allow", 32'(rd_allow), 0);
    check("rst_wr_allow", 32'(wr_allow), 1);
    check("rst_data", 32'(dout), 0);
    tick(); settle(); check("idle_turn1", 32'(rw_turn), 1);
    tick(); settle(); check("idle_turn2", 32'(rw_turn), 0);
    tick(); settle(); check("idle_turn3", 32'(rw_turn), 1);

    // Write 0xA5 at 3, read it back on the following read turn
    to_turn(1);
    we = 1'b1; wp = 4'd3; rp = 4'd3; din = 8'hA5;
    tick();
    we = 1'b0; wp = 4'd4;
    settle();
    check("one_word_fill", 32'(fill), 1);
    tick(); settle();
    check("readback_a5", 32'(dout), 32'hA5);
    rp = 4'd4;
    tick(); tick();

    // Fill all 16 words
    do_reset();
    wp = '0; rp = '0;
    for (int i = 0; i < DEPTH; i++) begin
      to_turn(1);
      we = 1'b1; wp = AW'(i); din = W'($urandom); saved[i] = din;
      tick();
      we = 1'b0; wp = AW'(i + 1);
    end
    settle();
    check("full_fill", 32'(fill), 16);
    check("full_wr_allow", 32'(wr_allow), 0);
    check("full_rd_allow", 32'(rd_allow), 1);

    // 17th write is refused
    to_turn(1);
    we = 1'b1; wp = 4'd0; din = 8'hFF;
    tick();
    we = 1'b0;
    settle();
    check("drop_pulse", 32'(drop), 1);
    tick(); settle();
    check("drop_once", 32'(drop), 0);

    // Consume one word
    rp = 4'd1;
    tick(); settle();
    check("release_wr_allow", 32'(wr_allow), 1);
    check("release_fill", 32'(fill), 15);

    // Refill, then reset while full
    to_turn(1);
    we = 1'b1; wp = 4'd0; din = 8'h5A; saved[0] = din;
    tick();
    we = 1'b0; wp = 4'd1;
    settle();
    check("refull_fill", 32'(fill), 16);
    do_reset();
    settle();
    check("mid_rst_turn", 32'(rw_turn), 0);
    check("mid_rst_fill", 32'(fill), 0);
    check("mid_rst_drop", 32'(drop), 0);
    rp = 4'd5;
    tick(); settle();
    check("ram_kept", 32'(dout), 32'(saved[5]));

    // Wrap-around fill level
    wp = 4'd2; rp = 4'd14;
    settle();
    check("wrap_fill", 32'(fill), 4);

    // Commit and read-pointer change in the same cycle
    to_turn(0);
    rp = 4'd13; wp = 4'd2;
    tick();
    rp = 4'd14; wp = 4'd14; we = 1'b1; din = 8'h77;
    tick();
    we = 1'b0;
    settle();
    check("set_wins_fill", 32'(fill), 16);
    check("set_wins_wr_allow", 32'(wr_allow), 0);

    // Randomised logger-like traffic, checked by the model every cycle
    for (int c = 0; c < 3000; c++) begin
      int r;
      we  = 1'($urandom_range(0, 1));
      din = W'($urandom);
      r = $urandom_range(0, 9);
      if (r < 2) wp = wp + 1'b1; else if (r == 9) wp = AW'($urandom);
      r = $urandom_range(0, 9);
      if (r < 2) rp = rp + 1'b1; else if (r == 9) rp = AW'($urandom);
      rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 1'b0; we = 1'b0;
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
